// File: rtl/mm_data_arb_pkg.sv
// mm_data_arb_pkg: shared types and helpers for the two-master RAM data-port arbiter.
package mm_data_arb_pkg;

    typedef enum logic {
        MST_CORE   = 1'b0,
        MST_LOADER = 1'b1
    } mst_id_e;

    localparam int MM_ADDR_W = 32;

    typedef struct packed {
        logic [MM_ADDR_W-1:0] addr;
        logic                 we;
        logic [3:0]           be;
        logic [31:0]          wdata;
    } mm_req_t;

    function automatic int lock_cnt_w(int lock_max);
        return $clog2(lock_max + 1);
    endfunction

endpackage

// File: rtl/mm_data_arb_if.sv
// mm_data_arb_if: one master's request/response bundle toward the data-port arbiter.
interface mm_data_arb_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (output req, lock, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, lock, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mm_data_arb_sel.sv
// mm_data_arb_sel: combinational winner pick (lock hold, sole requester, contention policy).
// MM_DATA_ARB_RR_EN selects round-robin contention; otherwise master 0 has fixed priority.
module mm_data_arb_sel
    import mm_data_arb_pkg::*;
#(
    parameter int LOCK_MAX   = 16,
    parameter int LOCK_CNT_W = lock_cnt_w(LOCK_MAX)
) (
    input  logic [1:0]            req_i,
    input  logic                  lock_vld_i,
    input  mst_id_e               own_i,
    input  logic [LOCK_CNT_W-1:0] cnt_i,
    output logic                  gnt_o,
    output mst_id_e               id_o,
    output logic                  hold_o
);
    logic    own_req;
    logic    expired;
    logic    both;
    mst_id_e other;
    mst_id_e contend_id;

    assign other   = mst_id_e'(~own_i);
    assign own_req = (own_i == MST_LOADER) ? req_i[1] : req_i[0];
    assign both    = &req_i;
    assign gnt_o   = |req_i;
    assign hold_o  = lock_vld_i && own_req && (cnt_i < LOCK_CNT_W'(LOCK_MAX));
    // An exhausted lock hands contention to the other master in both builds.
    assign expired = lock_vld_i && own_req && !hold_o;

`ifdef MM_DATA_ARB_RR_EN
    assign contend_id = other;
`else
    assign contend_id = MST_CORE;
`endif

    always_comb begin
        id_o = hold_o             ? own_i :
               (expired && both)  ? other :
               both               ? contend_id :
               req_i[1]           ? MST_LOADER : MST_CORE;
    end

endmodule

// File: rtl/mm_data_arb.sv
// mm_data_arb: shares the RAM data port between core LSU (m0) and loader (m1), with locked RMW.
// Define MM_DATA_ARB_RR_EN for round-robin contention; default build is fixed priority to m0.
module mm_data_arb
    import mm_data_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    mm_data_arb_if.slave          m0_if,
    mm_data_arb_if.slave          m1_if,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);
    localparam int LOCK_CNT_W = lock_cnt_w(LOCK_MAX);

    logic                  gnt;
    logic                  hold;
    logic                  win_lock;
    mst_id_e               gnt_id;
    mm_req_t               req0, req1, win;
    mst_id_e               own_q, own_d, rid_q, rid_d;
    logic                  lock_q, lock_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rwe_q, rwe_d;
    logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;

    mm_data_arb_sel #(
        .LOCK_MAX  (LOCK_MAX),
        .LOCK_CNT_W(LOCK_CNT_W)
    ) u_sel (
        .req_i     ({m1_if.req, m0_if.req}),
        .lock_vld_i(rvalid_q && lock_q),
        .own_i     (own_q),
        .cnt_i     (cnt_q),
        .gnt_o     (gnt),
        .id_o      (gnt_id),
        .hold_o    (hold)
    );

    assign req0 = '{addr: MM_ADDR_W'(m0_if.addr), we: m0_if.we, be: m0_if.be, wdata: m0_if.wdata};
    assign req1 = '{addr: MM_ADDR_W'(m1_if.addr), we: m1_if.we, be: m1_if.be, wdata: m1_if.wdata};
    assign win      = !gnt ? '0 : (gnt_id == MST_LOADER) ? req1 : req0;
    assign win_lock = (gnt_id == MST_LOADER) ? m1_if.lock : m0_if.lock;

    assign ram_addr_o  = ADDR_WIDTH'(win.addr);
    assign ram_we_o    = win.we;
    assign ram_be_o    = win.be;
    assign ram_wdata_o = win.wdata;

    assign m0_if.gnt    = gnt && (gnt_id == MST_CORE);
    assign m1_if.gnt    = gnt && (gnt_id == MST_LOADER);
    assign m0_if.rvalid = rvalid_q && (rid_q == MST_CORE);
    assign m1_if.rvalid = rvalid_q && (rid_q == MST_LOADER);
    assign m0_if.rdata  = (m0_if.rvalid && !rwe_q) ? ram_rdata_i : '0;
    assign m1_if.rdata  = (m1_if.rvalid && !rwe_q) ? ram_rdata_i : '0;

    always_comb begin
        cnt_d    = hold ? cnt_q + LOCK_CNT_W'(1) : '0;
        own_d    = gnt ? gnt_id : own_q;
        lock_d   = gnt ? win_lock : lock_q;
        rvalid_d = gnt;
        rid_d    = gnt ? gnt_id : rid_q;
        rwe_d    = gnt ? win.we : rwe_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            own_q    <= MST_LOADER;
            lock_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rid_q    <= MST_CORE;
            rwe_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            own_q    <= own_d;
            lock_q   <= lock_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rwe_q    <= rwe_d;
        end
    end

endmodule

// File: tb/tb_mm_data_arb.sv
// tb_mm_data_arb: directed bench for mm_data_arb with a byte-enabled one-cycle RAM model.
module tb_mm_data_arb;
    logic        clk;
    logic        rst_n;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] mem [0:1023];
    int          n_vec = 0;
    int          n_err = 0;

`ifdef MM_DATA_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mm_data_arb_if #(.ADDR_WIDTH(32)) m0 ();
    mm_data_arb_if #(.ADDR_WIDTH(32)) m1 ();

    mm_data_arb #(.ADDR_WIDTH(32), .LOCK_MAX(3)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m0_if      (m0),
        .m1_if      (m1),
        .ram_addr_o (ram_addr),
        .ram_we_o   (ram_we),
        .ram_be_o   (ram_be),
        .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        ram_rdata <= mem[ram_addr[11:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int n, input logic req, input logic lock, input logic we,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        if (n == 0) begin
            m0.req = req; m0.lock = lock; m0.we = we; m0.addr = addr; m0.be = be; m0.wdata = wd;
        end else begin
            m1.req = req; m1.lock = lock; m1.we = we; m1.addr = addr; m1.be = be; m1.wdata = wd;
        end
    endtask

    task automatic idle();
        set_m(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        set_m(1, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (m0.rvalid !== 1'b0) begin n_err++; $display("FAIL reset m0_rvalid: got %b exp 0", m0.rvalid); end
        n_vec++; if (m1.rvalid !== 1'b0) begin n_err++; $display("FAIL reset m1_rvalid: got %b exp 0", m1.rvalid); end
        n_vec++; if (m0.rdata !== 32'h0) begin n_err++; $display("FAIL reset m0_rdata: got %h exp 0", m0.rdata); end
        n_vec++; if (m1.rdata !== 32'h0) begin n_err++; $display("FAIL reset m1_rdata: got %h exp 0", m1.rdata); end
        n_vec++; if (ram_we !== 1'b0 || ram_be !== 4'h0) begin n_err++; $display("FAIL reset ram_we/be: got %b/%b exp 0/0000", ram_we, ram_be); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        set_m(0, 1, 0, 0, 32'h100, 4'hF, 32'h0);
        #1;
        n_vec++; if (m0.gnt !== 1'b1 || m1.gnt !== 1'b0) begin n_err++; $display("FAIL single gnt: got m0=%b m1=%b exp 1/0", m0.gnt, m1.gnt); end
        n_vec++; if (ram_addr !== 32'h100 || ram_we !== 1'b0) begin n_err++; $display("FAIL single ram_addr/we: got %h/%b exp 00000100/0", ram_addr, ram_we); end
        n_vec++; if (m0.rvalid !== 1'b0) begin n_err++; $display("FAIL single early rvalid: got %b exp 0", m0.rvalid); end
        step();
        idle();
        #1;
        n_vec++; if (m0.rvalid !== 1'b1) begin n_err++; $display("FAIL single m0_rvalid: got %b exp 1", m0.rvalid); end
        n_vec++; if (m0.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single m0_rdata: got %h exp deadbeef", m0.rdata); end
        n_vec++; if (m1.rvalid !== 1'b0 || m1.rdata !== 32'h0) begin n_err++; $display("FAIL single m1 quiet: got %b/%h exp 0/0", m1.rvalid, m1.rdata); end
        n_vec++; if (ram_we !== 1'b0 || ram_be !== 4'h0 || ram_addr !== 32'h0) begin n_err++; $display("FAIL single idle bus: got %b/%b/%h exp 0/0/0", ram_we, ram_be, ram_addr); end
        step();
        #1;
        n_vec++; if (m0.rvalid !== 1'b0) begin n_err++; $display("FAIL single rvalid drop: got %b exp 0", m0.rvalid); end
    endtask

    task automatic test_contention();
        int exp_id, prev_id;
        apply_reset();
        prev_id = -1;
        for (int k = 0; k < 5; k++) begin
            set_m(0, k < 4, 0, 0, 32'h100, 4'hF, 32'h0);
            set_m(1, 1, 0, 0, 32'h200, 4'hF, 32'h0);
            #1;
            exp_id = (k == 4) ? 1 : (RR ? k % 2 : 0);
            n_vec++; if (m0.gnt !== (exp_id == 0) || m1.gnt !== (exp_id == 1)) begin n_err++; $display("FAIL contention gnt cyc %0d: got m0=%b m1=%b exp owner m%0d", k, m0.gnt, m1.gnt, exp_id); end
            if (prev_id >= 0) begin
                n_vec++; if (m0.rvalid !== (prev_id == 0) || m1.rvalid !== (prev_id == 1)) begin n_err++; $display("FAIL contention rvalid cyc %0d: got m0=%b m1=%b exp owner m%0d", k, m0.rvalid, m1.rvalid, prev_id); end
                n_vec++;
                if (prev_id == 0 ? (m0.rdata !== 32'hDEADBEEF) : (m1.rdata !== 32'hAABBCCDD)) begin
                    n_err++; $display("FAIL contention rdata cyc %0d: got m0=%h m1=%h exp from m%0d", k, m0.rdata, m1.rdata, prev_id);
                end
            end
            prev_id = exp_id;
            step();
        end
        idle();
        #1;
        n_vec++; if (m1.rvalid !== 1'b1 || m1.rdata !== 32'hAABBCCDD) begin n_err++; $display("FAIL contention last resp: got %b/%h exp 1/aabbccdd", m1.rvalid, m1.rdata); end
        step();
    endtask

    task automatic test_lock();
        int exp_id;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            set_m(0, 1, 1, 0, 32'h100, 4'hF, 32'h0);
            set_m(1, 1, 0, 0, 32'h200, 4'hF, 32'h0);
            #1;
            exp_id = (k == 4) ? 1 : 0;
            n_vec++; if (m0.gnt !== (exp_id == 0) || m1.gnt !== (exp_id == 1)) begin n_err++; $display("FAIL lock gnt cyc %0d: got m0=%b m1=%b exp owner m%0d", k, m0.gnt, m1.gnt, exp_id); end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_lock_restart();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            set_m(0, k < 7, 1, 0, 32'h100, 4'hF, 32'h0);
            set_m(1, k >= 6, 0, 0, 32'h200, 4'hF, 32'h0);
            #1;
            if (k == 6) begin
                n_vec++; if (m0.gnt !== 1'b1 || m1.gnt !== 1'b0) begin n_err++; $display("FAIL lock_restart hold: got m0=%b m1=%b exp 1/0", m0.gnt, m1.gnt); end
            end else if (k == 7) begin
                n_vec++; if (m0.gnt !== 1'b0 || m1.gnt !== 1'b1) begin n_err++; $display("FAIL lock_drop: got m0=%b m1=%b exp 0/1", m0.gnt, m1.gnt); end
            end else begin
                n_vec++; if (m0.gnt !== 1'b1) begin n_err++; $display("FAIL lock_restart sole cyc %0d: got %b exp 1", k, m0.gnt); end
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_write();
        apply_reset();
        set_m(1, 1, 0, 1, 32'h200, 4'b0011, 32'h12345678);
        #1;
        n_vec++; if (m1.gnt !== 1'b1) begin n_err++; $display("FAIL write gnt: got %b exp 1", m1.gnt); end
        n_vec++; if (ram_we !== 1'b1 || ram_be !== 4'b0011) begin n_err++; $display("FAIL write we/be: got %b/%b exp 1/0011", ram_we, ram_be); end
        n_vec++; if (ram_addr !== 32'h200 || ram_wdata !== 32'h12345678) begin n_err++; $display("FAIL write addr/data: got %h/%h exp 00000200/12345678", ram_addr, ram_wdata); end
        step();
        set_m(1, 1, 0, 0, 32'h200, 4'hF, 32'h0);
        #1;
        n_vec++; if (m1.rvalid !== 1'b1 || m1.rdata !== 32'h0) begin n_err++; $display("FAIL write resp: got %b/%h exp 1/00000000", m1.rvalid, m1.rdata); end
        n_vec++; if (m0.rvalid !== 1'b0) begin n_err++; $display("FAIL write m0 quiet: got %b exp 0", m0.rvalid); end
        step();
        idle();
        #1;
        n_vec++; if (m1.rvalid !== 1'b1 || m1.rdata !== 32'hAABB5678) begin n_err++; $display("FAIL write readback: got %b/%h exp 1/aabb5678", m1.rvalid, m1.rdata); end
        step();
    endtask

    task automatic test_reset_midop();
        apply_reset();
        set_m(1, 1, 0, 0, 32'h200, 4'hF, 32'h0);
        step();
        set_m(1, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        set_m(0, 1, 0, 0, 32'h100, 4'hF, 32'h0);
        #1;
        n_vec++; if (m0.gnt !== 1'b1) begin n_err++; $display("FAIL midop gnt: got %b exp 1", m0.gnt); end
        step();
        idle();
        rst_n = 1'b0;
        #1;
        n_vec++; if (m0.rvalid !== 1'b0 || m0.rdata !== 32'h0) begin n_err++; $display("FAIL midop async drop: got %b/%h exp 0/0", m0.rvalid, m0.rdata); end
        step();
        rst_n = 1'b1;
        #1;
        n_vec++; if (m0.rvalid !== 1'b0 || m1.rvalid !== 1'b0) begin n_err++; $display("FAIL midop after release: got %b/%b exp 0/0", m0.rvalid, m1.rvalid); end
        set_m(0, 1, 0, 0, 32'h100, 4'hF, 32'h0);
        set_m(1, 1, 0, 0, 32'h200, 4'hF, 32'h0);
        #1;
        n_vec++; if (m0.gnt !== 1'b1 || m1.gnt !== 1'b0) begin n_err++; $display("FAIL midop first contention: got m0=%b m1=%b exp 1/0", m0.gnt, m1.gnt); end
        step();
        idle();
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h200 >> 2] = 32'hAABBCCDD;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_lock_restart();
        test_write();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
